// File: rtl/syn_lb_arb_if.sv
// Bundle of requester (m0/m1) and shared local-bus signals for syn_lb_arb.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface syn_lb_arb_if #(
  parameter int P_LB_DATA_W = 32,
  parameter int P_LB_ADDR_W = 12
);
  logic                   m0_wr_en;
  logic                   m0_rd_en;
  logic [P_LB_ADDR_W-1:0] m0_addr;
  logic [P_LB_DATA_W-1:0] m0_wr_data;
  logic                   m0_wr_valid;
  logic                   m0_rd_valid;
  logic [P_LB_DATA_W-1:0] m0_rd_data;

  logic                   m1_wr_en;
  logic                   m1_rd_en;
  logic [P_LB_ADDR_W-1:0] m1_addr;
  logic [P_LB_DATA_W-1:0] m1_wr_data;
  logic                   m1_wr_valid;
  logic                   m1_rd_valid;
  logic [P_LB_DATA_W-1:0] m1_rd_data;

  logic                   lb_wr_en;
  logic                   lb_rd_en;
  logic [P_LB_ADDR_W-1:0] lb_addr;
  logic [P_LB_DATA_W-1:0] lb_wr_data;
  logic                   lb_wr_valid;
  logic                   lb_rd_valid;
  logic [P_LB_DATA_W-1:0] lb_rd_data;

  logic                   tmo_sticky;

  modport slave (
    input  m0_wr_en, m0_rd_en, m0_addr, m0_wr_data,
    output m0_wr_valid, m0_rd_valid, m0_rd_data,
    input  m1_wr_en, m1_rd_en, m1_addr, m1_wr_data,
    output m1_wr_valid, m1_rd_valid, m1_rd_data,
    output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data,
    output tmo_sticky
  );

  modport master (
    output m0_wr_en, m0_rd_en, m0_addr, m0_wr_data,
    input  m0_wr_valid, m0_rd_valid, m0_rd_data,
    output m1_wr_en, m1_rd_en, m1_addr, m1_wr_data,
    input  m1_wr_valid, m1_rd_valid, m1_rd_data,
    input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid, lb_rd_data,
    input  tmo_sticky
  );
endinterface

// File: rtl/syn_lb_arb.sv
// Two-requester round-robin arbiter onto one shared local bus, one transaction in flight.
// Optional response timeout is enabled by defining SYN_LB_ARB_TIMEOUT_EN.
module syn_lb_arb #(
  parameter int P_LB_DATA_W  = 32,
  parameter int P_LB_ADDR_W  = 12,
  parameter int P_TMO_CYCLES = 255
) (
  input  logic        clk_ir,
  input  logic        rst_il,
  syn_lb_arb_if.slave lb_if
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  if (P_TMO_CYCLES < 1 || P_TMO_CYCLES > 255) begin : g_bad_tmo
    $error("P_TMO_CYCLES must lie in 1..255");
  end

  state_t                 r_state;
  logic                   r_gnt;
  logic                   r_last;
  logic                   r_op_wr;
  logic                   r_lb_wr_en;
  logic                   r_lb_rd_en;
  logic [P_LB_ADDR_W-1:0] r_lb_addr;
  logic [P_LB_DATA_W-1:0] r_lb_wr_data;
  logic                   r_m0_wr_valid;
  logic                   r_m0_rd_valid;
  logic [P_LB_DATA_W-1:0] r_m0_rd_data;
  logic                   r_m1_wr_valid;
  logic                   r_m1_rd_valid;
  logic [P_LB_DATA_W-1:0] r_m1_rd_data;

  logic                   w_m0_pend;
  logic                   w_m1_pend;
  logic                   w_pick;
  logic                   w_sel_wr;
  logic [P_LB_ADDR_W-1:0] w_sel_addr;
  logic [P_LB_DATA_W-1:0] w_sel_wdata;
  logic                   w_rsp_hit;
  logic                   w_tmo;
  logic [P_LB_DATA_W-1:0] w_rsp_data;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_m0_pend   = lb_if.m0_wr_en | lb_if.m0_rd_en;
    w_m1_pend   = lb_if.m1_wr_en | lb_if.m1_rd_en;
    // On a tie the master that did not win last time goes next.
    w_pick      = (w_m0_pend && w_m1_pend) ? ~r_last : w_m1_pend;
    w_sel_wr    = w_pick ? lb_if.m1_wr_en   : lb_if.m0_wr_en;
    w_sel_addr  = w_pick ? lb_if.m1_addr    : lb_if.m0_addr;
    w_sel_wdata = w_pick ? lb_if.m1_wr_data : lb_if.m0_wr_data;
    w_rsp_hit   = r_op_wr ? lb_if.lb_wr_valid : lb_if.lb_rd_valid;
  end

`ifdef SYN_LB_ARB_TIMEOUT_EN
  localparam logic [7:0]             LP_TMO_LAST = 8'(P_TMO_CYCLES - 1);
  localparam logic [P_LB_DATA_W-1:0] LP_TMO_DATA = P_LB_DATA_W'(32'hDEAD_DEAD);

  logic [7:0] r_tmo_cnt;
  logic       r_tmo_sticky;

  assign w_tmo      = (r_state == S_WAIT) && !w_rsp_hit && (r_tmo_cnt == LP_TMO_LAST);
  assign w_rsp_data = w_tmo ? LP_TMO_DATA : lb_if.lb_rd_data;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_tmo_cnt    <= 8'd0;
      r_tmo_sticky <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_tmo_cnt <= 8'd0;
      else if (r_state == S_WAIT && !w_rsp_hit)
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_tmo)
        r_tmo_sticky <= 1'b1;
    end
  end

  assign lb_if.tmo_sticky = r_tmo_sticky;
`else
  assign w_tmo            = 1'b0;
  assign w_rsp_data       = lb_if.lb_rd_data;
  assign lb_if.tmo_sticky = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_state       <= S_IDLE;
      r_gnt         <= 1'b0;
      r_last        <= 1'b1;
      r_op_wr       <= 1'b0;
      r_lb_wr_en    <= 1'b0;
      r_lb_rd_en    <= 1'b0;
      r_lb_addr     <= '0;
      r_lb_wr_data  <= '0;
      r_m0_wr_valid <= 1'b0;
      r_m0_rd_valid <= 1'b0;
      r_m0_rd_data  <= '0;
      r_m1_wr_valid <= 1'b0;
      r_m1_rd_valid <= 1'b0;
      r_m1_rd_data  <= '0;
    end else begin
      r_lb_wr_en    <= 1'b0;
      r_lb_rd_en    <= 1'b0;
      r_m0_wr_valid <= 1'b0;
      r_m0_rd_valid <= 1'b0;
      r_m1_wr_valid <= 1'b0;
      r_m1_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_m0_pend || w_m1_pend) begin
            r_gnt        <= w_pick;
            r_op_wr      <= w_sel_wr;
            r_lb_addr    <= w_sel_addr;
            r_lb_wr_data <= w_sel_wdata;
            r_lb_wr_en   <= w_sel_wr;
            r_lb_rd_en   <= !w_sel_wr;
            r_state      <= S_ISSUE;
          end
        end
        // A response during the command cycle itself is taken exactly as one in WAIT.
        S_ISSUE, S_WAIT: begin
          if (w_rsp_hit || w_tmo) begin
            r_state <= S_RESP;
            if (r_op_wr) begin
              if (r_gnt) r_m1_wr_valid <= 1'b1;
              else       r_m0_wr_valid <= 1'b1;
            end else if (r_gnt) begin
              r_m1_rd_valid <= 1'b1;
              r_m1_rd_data  <= w_rsp_data;
            end else begin
              r_m0_rd_valid <= 1'b1;
              r_m0_rd_data  <= w_rsp_data;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lb_if.lb_wr_en    = r_lb_wr_en;
  assign lb_if.lb_rd_en    = r_lb_rd_en;
  assign lb_if.lb_addr     = r_lb_addr;
  assign lb_if.lb_wr_data  = r_lb_wr_data;
  assign lb_if.m0_wr_valid = r_m0_wr_valid;
  assign lb_if.m0_rd_valid = r_m0_rd_valid;
  assign lb_if.m0_rd_data  = r_m0_rd_data;
  assign lb_if.m1_wr_valid = r_m1_wr_valid;
  assign lb_if.m1_rd_valid = r_m1_rd_valid;
  assign lb_if.m1_rd_data  = r_m1_rd_data;

endmodule
